// File: rtl/data_memory_io_pkg.sv
// rtl/data_memory_io_pkg.sv - I/O address map, STATUS bit positions and UART state encoding
package data_memory_io_pkg;

    localparam logic [7:0] ADDR_GPIO_OUT  = 8'hF0;
    localparam logic [7:0] ADDR_GPIO_IN   = 8'hF1;
    localparam logic [7:0] ADDR_TIMER_CNT = 8'hF2;
    localparam logic [7:0] ADDR_TIMER_CMP = 8'hF3;
    localparam logic [7:0] ADDR_STATUS    = 8'hF4;
    localparam logic [7:0] ADDR_UART_TX   = 8'hF5;

    localparam int STATUS_MATCH_BIT = 0;
    localparam int STATUS_BUSY_BIT  = 1;

    typedef enum logic [1:0] {
        UART_IDLE  = 2'd0,
        UART_START = 2'd1,
        UART_DATA  = 2'd2,
        UART_STOP  = 2'd3
    } uart_state_e;

endpackage

// File: rtl/data_memory_io_uart_tx.sv
// rtl/data_memory_io_uart_tx.sv - 8N1 UART transmitter: baud counter, shift register and framing FSM
module data_memory_io_uart_tx
    import data_memory_io_pkg::*;
#(
    parameter int BAUD_DIV = 868
) (
    input  logic       clk,
    input  logic       res,
    input  logic       start,
    input  logic [7:0] data,
    output logic       busy,
    output logic       txd
);

    localparam int                BAUD_W    = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);

    uart_state_e       r_state;
    uart_state_e       w_state_next;
    logic [BAUD_W-1:0] r_baud_cnt;
    logic [2:0]        r_bit_cnt;
    logic [7:0]        r_shift;
    logic              w_baud_done;
    logic              w_accept;

    assign w_baud_done = (r_baud_cnt == BAUD_LAST);
    assign w_accept    = start && (r_state == UART_IDLE);

    always_ff @(posedge clk) begin
        if (res) begin
            r_state <= UART_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            UART_IDLE:  if (start)                                w_state_next = UART_START;
            UART_START: if (w_baud_done)                          w_state_next = UART_DATA;
            UART_DATA:  if (w_baud_done && (r_bit_cnt == 3'd7))   w_state_next = UART_STOP;
            UART_STOP:  if (w_baud_done)                          w_state_next = UART_IDLE;
            default:                                              w_state_next = UART_IDLE;
        endcase
    end

    // Baud counter restarts on every state change; data shifts out LSB first
    always_ff @(posedge clk) begin
        if (res) begin
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
        end else if (w_accept) begin
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= data;
        end else if (r_state != UART_IDLE) begin
            r_baud_cnt <= w_baud_done ? '0 : r_baud_cnt + 1'b1;
            if ((r_state == UART_DATA) && w_baud_done) begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
                r_shift   <= {1'b0, r_shift[7:1]};
            end
        end
    end

    always_comb begin
        busy = 1'b1;
        txd  = 1'b1;
        case (r_state)
            UART_IDLE:  busy = 1'b0;
            UART_START: txd  = 1'b0;
            UART_DATA:  txd  = r_shift[0];
            UART_STOP:  txd  = 1'b1;
            default: begin
                busy = 1'b0;
                txd  = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/data_memory_io.sv
// rtl/data_memory_io.sv - data RAM plus memory-mapped GPIO, timer and UART behind the core's MAR/MDR
module data_memory_io
    import data_memory_io_pkg::*;
#(
    parameter int RAM_DEPTH      = 240,
    parameter int TIMER_PRESCALE = 256,
    parameter int BAUD_DIV       = 868
) (
    input  logic       clk,
    input  logic       res,
    input  logic [7:0] mar_in,
    input  logic [7:0] mdr_wr_data,
    input  logic       write_mem,
    output logic [7:0] mdr_rd_data,
    input  logic [7:0] gpio_in,
    output logic [7:0] gpio_out,
    output logic       uart_txd,
    output logic       timer_irq
);

    localparam int               RAM_AW    = $clog2(RAM_DEPTH);
    localparam logic [8:0]       RAM_LIMIT = 9'(RAM_DEPTH);
    localparam int               PRE_W     = (TIMER_PRESCALE > 2) ? $clog2(TIMER_PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(TIMER_PRESCALE - 1);

    logic [7:0]       r_ram [RAM_DEPTH];
    logic [7:0]       r_rd_data;
    logic [7:0]       r_gpio_out;
    logic [7:0]       r_gpio_sync1;
    logic [7:0]       r_gpio_sync2;
    logic [PRE_W-1:0] r_prescale;
    logic [7:0]       r_timer_cnt;
    logic [7:0]       r_timer_cmp;
    logic             r_match;

    logic             w_in_ram;
    logic             w_wr_ram;
    logic             w_wr_gpio;
    logic             w_wr_cnt;
    logic             w_wr_cmp;
    logic             w_wr_status;
    logic             w_uart_start;
    logic             w_uart_busy;
    logic             w_wrap;
    logic             w_match_set;
    logic             w_match_clr;
    logic [7:0]       w_cnt_inc;
    logic [7:0]       w_ram_rd;
    logic [7:0]       w_rd_mux;

    assign w_in_ram     = ({1'b0, mar_in} < RAM_LIMIT);
    assign w_wr_ram     = write_mem && w_in_ram;
    assign w_wr_gpio    = write_mem && (mar_in == ADDR_GPIO_OUT);
    assign w_wr_cnt     = write_mem && (mar_in == ADDR_TIMER_CNT);
    assign w_wr_cmp     = write_mem && (mar_in == ADDR_TIMER_CMP);
    assign w_wr_status  = write_mem && (mar_in == ADDR_STATUS);
    assign w_uart_start = write_mem && (mar_in == ADDR_UART_TX);

    // RAM has no reset, so writes land even while res is high
    always_ff @(posedge clk) begin
        if (w_wr_ram) begin
            r_ram[mar_in[RAM_AW-1:0]] <= mdr_wr_data;
        end
    end

    assign w_ram_rd = r_ram[mar_in[RAM_AW-1:0]];

    always_ff @(posedge clk) begin
        if (res) begin
            r_gpio_out   <= 8'h00;
            r_gpio_sync1 <= 8'h00;
            r_gpio_sync2 <= 8'h00;
        end else begin
            if (w_wr_gpio) begin
                r_gpio_out <= mdr_wr_data;
            end
            r_gpio_sync1 <= gpio_in;
            r_gpio_sync2 <= r_gpio_sync1;
        end
    end

    assign w_wrap      = (r_prescale == PRE_LAST);
    assign w_cnt_inc   = r_timer_cnt + 8'd1;
    assign w_match_set = w_wrap && !w_wr_cnt && (w_cnt_inc == r_timer_cmp);
    assign w_match_clr = w_wr_status && mdr_wr_data[STATUS_MATCH_BIT];

    // A count write beats a same-edge wrap; a match beats a same-edge clear
    always_ff @(posedge clk) begin
        if (res) begin
            r_prescale  <= '0;
            r_timer_cnt <= 8'h00;
            r_timer_cmp <= 8'hFF;
            r_match     <= 1'b0;
        end else begin
            if (w_wr_cnt) begin
                r_prescale  <= '0;
                r_timer_cnt <= 8'h00;
            end else if (w_wrap) begin
                r_prescale  <= '0;
                r_timer_cnt <= w_cnt_inc;
            end else begin
                r_prescale  <= r_prescale + 1'b1;
            end
            if (w_wr_cmp) begin
                r_timer_cmp <= mdr_wr_data;
            end
            if (w_match_set) begin
                r_match <= 1'b1;
            end else if (w_match_clr) begin
                r_match <= 1'b0;
            end
        end
    end

    data_memory_io_uart_tx #(
        .BAUD_DIV (BAUD_DIV)
    ) u_uart_tx (
        .clk   (clk),
        .res   (res),
        .start (w_uart_start),
        .data  (mdr_wr_data),
        .busy  (w_uart_busy),
        .txd   (uart_txd)
    );

    always_comb begin
        w_rd_mux = 8'h00;
        if (w_in_ram) begin
            w_rd_mux = w_ram_rd;
        end else begin
            case (mar_in)
                ADDR_GPIO_OUT:  w_rd_mux = r_gpio_out;
                ADDR_GPIO_IN:   w_rd_mux = r_gpio_sync2;
                ADDR_TIMER_CNT: w_rd_mux = r_timer_cnt;
                ADDR_TIMER_CMP: w_rd_mux = r_timer_cmp;
                ADDR_STATUS: begin
                    w_rd_mux[STATUS_MATCH_BIT] = r_match;
                    w_rd_mux[STATUS_BUSY_BIT]  = w_uart_busy;
                end
                default:        w_rd_mux = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            r_rd_data <= 8'h00;
        end else begin
            r_rd_data <= w_rd_mux;
        end
    end

    assign mdr_rd_data = r_rd_data;
    assign gpio_out    = r_gpio_out;
    assign timer_irq   = r_match;

endmodule
